writeback_regfile: RTL and testbench

Writeback end of the five-stage Y86-64 pipeline: the W pipeline register, the 15×64-bit program register file, and the retirement/status machine. It captures memory-stage results, commits them to the register file, and serves the decode stage's two combinational read ports. It exports W-stage values for forwarding and for PC selection (W_icode/W_valM for `ret`), and owns the architectural CPU status, which is sticky after halt or fault.

---
 rtl/y86_pkg.sv | 40 ++++
 rtl/regfile_2r2w.sv | 65 ++++++
 rtl/writeback_regfile.sv | 138 +++++++++++++
 tb/tb_writeback_regfile.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants used by the writeback end of the pipeline.
// Contents: status codes, instruction codes, register ids, and the
// retirement state enum.
package y86_pkg;

  // Status codes
  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SADR = 3'd2;
  localparam logic [2:0] SINS = 3'd3;
  localparam logic [2:0] SHLT = 3'd4;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Register ids
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam int NUM_REGS = 15;

  // Retirement state; HALT and FAULT are sticky until reset
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } cpu_state_e;

endpackage

// File: rtl/regfile_2r2w.sv
// 15 x DATA_W Y86-64 program register file.
// Ports:
//   clk_i, rst_n_i         clock / async active-low reset (clears all regs)
//   we_e_i/dst_e_i/val_e_i E write port
//   we_m_i/dst_m_i/val_m_i M write port, wins over E on the same address
//   src_a_i/src_b_i        combinational read addresses (RNONE reads 0)
//   rval_a_o/rval_b_o      read data
// Optional feature: WB_READ_BYPASS_EN -- reads that hit an enabled write
// in the same cycle return the write data (M over E).
module regfile_2r2w
  import y86_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_e_i,
  input  logic [3:0]        dst_e_i,
  input  logic [DATA_W-1:0] val_e_i,
  input  logic              we_m_i,
  input  logic [3:0]        dst_m_i,
  input  logic [DATA_W-1:0] val_m_i,
  input  logic [3:0]        src_a_i,
  input  logic [3:0]        src_b_i,
  output logic [DATA_W-1:0] rval_a_o,
  output logic [DATA_W-1:0] rval_b_o
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic                   wr_e, wr_m;
  logic [1:0][3:0]        src;
  logic [1:0][DATA_W-1:0] rval;

  // RNONE never names storage, so it is filtered here as well
  assign wr_e = we_e_i && (dst_e_i != RNONE);
  assign wr_m = we_m_i && (dst_m_i != RNONE);

  // M write is issued last so it overrides E on equal addresses (popq %rsp)
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      if (wr_e) regs[dst_e_i] <= val_e_i;
      if (wr_m) regs[dst_m_i] <= val_m_i;
    end
  end

  assign src = {src_b_i, src_a_i};

  always_comb begin
    rval = '0;
    for (int p = 0; p < 2; p++) begin
      if (src[p] != RNONE) rval[p] = regs[src[p]];
`ifdef WB_READ_BYPASS_EN
      if (wr_e && (dst_e_i == src[p])) rval[p] = val_e_i;
      if (wr_m && (dst_m_i == src[p])) rval[p] = val_m_i;
`endif
    end
  end

  assign rval_a_o = rval[0];
  assign rval_b_o = rval[1];

endmodule

// File: rtl/writeback_regfile.sv
// Writeback end of the Y86-64 pipeline: W pipeline register, register
// file commit, and the sticky retirement/status machine.
// Ports:
//   clk_i, rst_n_i            clock / async active-low reset
//   W_stall_i, W_bubble_i     W register control (stall beats bubble)
//   m_*_i                     memory-stage results captured into W
//   W_*_o                     current W register contents (forwarding, ret)
//   d_srcA_i/d_srcB_i         decode read addresses
//   d_rvalA_o/d_rvalB_o       decode read data
//   cpu_stat_o, halted_o      architectural status
//   retired_cnt_o             retired instruction count (wraps)
// Optional feature: WB_READ_BYPASS_EN (see regfile_2r2w).
module writeback_regfile
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              W_stall_i,
  input  logic              W_bubble_i,
  input  logic [2:0]        m_stat_i,
  input  logic [3:0]        m_icode_i,
  input  logic [DATA_W-1:0] m_valE_i,
  input  logic [DATA_W-1:0] m_valM_i,
  input  logic [3:0]        m_dstE_i,
  input  logic [3:0]        m_dstM_i,
  output logic [2:0]        W_stat_o,
  output logic [3:0]        W_icode_o,
  output logic [DATA_W-1:0] W_valE_o,
  output logic [DATA_W-1:0] W_valM_o,
  output logic [3:0]        W_dstE_o,
  output logic [3:0]        W_dstM_o,
  input  logic [3:0]        d_srcA_i,
  input  logic [3:0]        d_srcB_i,
  output logic [DATA_W-1:0] d_rvalA_o,
  output logic [DATA_W-1:0] d_rvalB_o,
  output logic [2:0]        cpu_stat_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  retired_cnt_o
);

  typedef struct packed {
    logic [2:0]        stat;
    logic [3:0]        icode;
    logic [DATA_W-1:0] vale;
    logic [DATA_W-1:0] valm;
    logic [3:0]        dste;
    logic [3:0]        dstm;
  } wreg_t;

  localparam wreg_t W_BUBBLE = '{stat: SBUB, icode: INOP, vale: '0,
                                 valm: '0, dste: RNONE, dstm: RNONE};

  wreg_t      w_q;
  cpu_state_e state_q, state_d;
  logic [2:0] fcode_q, fcode_d;
  logic [CNT_W-1:0] retired_q;
  logic       commit;

  // W pipeline register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)        w_q <= W_BUBBLE;
    else if (W_stall_i)  w_q <= w_q;
    else if (W_bubble_i) w_q <= W_BUBBLE;
    else                 w_q <= '{stat: m_stat_i, icode: m_icode_i, vale: m_valE_i,
                                  valm: m_valM_i, dste: m_dstE_i, dstm: m_dstM_i};
  end

  // A stalled W entry neither retires nor changes state; it is looked at
  // again on the first unstalled edge.
  assign commit = (state_q == RUN) && (w_q.stat == SAOK) && !W_stall_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RUN;
      fcode_q <= SAOK;
    end else begin
      state_q <= state_d;
      fcode_q <= fcode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcode_d = fcode_q;
    if (state_q == RUN && !W_stall_i) begin
      case (w_q.stat)
        SHLT: state_d = HALT;
        SADR, SINS: begin
          state_d = FAULT;
          fcode_d = w_q.stat;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    retired_q <= '0;
    else if (commit) retired_q <= retired_q + CNT_W'(1);
  end

  regfile_2r2w #(.DATA_W(DATA_W)) u_rf (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .we_e_i   (commit),
    .dst_e_i  (w_q.dste),
    .val_e_i  (w_q.vale),
    .we_m_i   (commit),
    .dst_m_i  (w_q.dstm),
    .val_m_i  (w_q.valm),
    .src_a_i  (d_srcA_i),
    .src_b_i  (d_srcB_i),
    .rval_a_o (d_rvalA_o),
    .rval_b_o (d_rvalB_o)
  );

  always_comb begin
    cpu_stat_o = SAOK;
    case (state_q)
      HALT:    cpu_stat_o = SHLT;
      FAULT:   cpu_stat_o = fcode_q;
      default: cpu_stat_o = SAOK;
    endcase
  end

  assign halted_o      = (state_q != RUN);
  assign retired_cnt_o = retired_q;
  assign W_stat_o      = w_q.stat;
  assign W_icode_o     = w_q.icode;
  assign W_valE_o      = w_q.vale;
  assign W_valM_o      = w_q.valm;
  assign W_dstE_o      = w_q.dste;
  assign W_dstM_o      = w_q.dstm;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed table-driven bench for writeback_regfile (counter narrowed to
// 4 bits so wrap-around is reachable).
module tb_writeback_regfile;
  import y86_pkg::*;

  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          stall, bubble;
  logic [2:0]    m_stat;
  logic [3:0]    m_icode, m_dste, m_dstm, src_a, src_b;
  logic [DW-1:0] m_vale, m_valm;
  logic [2:0]    w_stat, cpu_stat;
  logic [3:0]    w_icode, w_dste, w_dstm;
  logic [DW-1:0] w_vale, w_valm, rva, rvb;
  logic          halted;
  logic [CW-1:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_regfile #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .W_stall_i(stall), .W_bubble_i(bubble),
    .m_stat_i(m_stat), .m_icode_i(m_icode), .m_valE_i(m_vale), .m_valM_i(m_valm),
    .m_dstE_i(m_dste), .m_dstM_i(m_dstm),
    .W_stat_o(w_stat), .W_icode_o(w_icode), .W_valE_o(w_vale), .W_valM_o(w_valm),
    .W_dstE_o(w_dste), .W_dstM_o(w_dstm),
    .d_srcA_i(src_a), .d_srcB_i(src_b), .d_rvalA_o(rva), .d_rvalB_o(rvb),
    .cpu_stat_o(cpu_stat), .halted_o(halted), .retired_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          st, bb;
    logic [2:0]    stat;
    logic [3:0]    icode;
    logic [DW-1:0] ve, vm;
    logic [3:0]    de, dm, sa, sb;
    logic [2:0]    x_ws;
    logic [3:0]    x_de, x_dm;
    logic [DW-1:0] x_ra, x_rb;
    logic [2:0]    x_cpu;
    logic          x_h;
    logic [CW-1:0] x_cnt;
  } vec_t;

  vec_t tv[11];

  function automatic vec_t mk(
      input logic st, bb, input logic [2:0] s, input logic [3:0] ic,
      input logic [DW-1:0] ve, vm, input logic [3:0] de, dm, sa, sb,
      input logic [2:0] xws, input logic [3:0] xde, xdm,
      input logic [DW-1:0] xra, xrb, input logic [2:0] xcpu, input logic xh,
      input logic [CW-1:0] xcnt);
    vec_t v;
    v.st = st; v.bb = bb; v.stat = s; v.icode = ic; v.ve = ve; v.vm = vm;
    v.de = de; v.dm = dm; v.sa = sa; v.sb = sb;
    v.x_ws = xws; v.x_de = xde; v.x_dm = xdm; v.x_ra = xra; v.x_rb = xrb;
    v.x_cpu = xcpu; v.x_h = xh; v.x_cnt = xcnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, bb, input logic [2:0] s, input logic [3:0] ic,
                       input logic [DW-1:0] ve, vm, input logic [3:0] de, dm);
    stall = st; bubble = bb; m_stat = s; m_icode = ic;
    m_vale = ve; m_valm = vm; m_dste = de; m_dstm = dm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, " W_stat"}, 64'(w_stat), 64'(SBUB));
    chk({tag, " W_dstE"}, 64'(w_dste), 64'(RNONE));
    chk({tag, " cpu_stat"}, 64'(cpu_stat), 64'(SAOK));
    chk({tag, " halted"}, 64'(halted), 64'd0);
    chk({tag, " retired"}, 64'(cnt), 64'd0);
    for (int r = 0; r < 15; r++) begin
      src_a = 4'(r);
      #1;
      chk($sformatf("%s reg%0d", tag, r), rva, 64'd0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 1, SBUB, INOP, 0, 0, RNONE, RNONE);
    src_a = RNONE; src_b = RNONE;
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    drive(0, 1, SBUB, INOP, 0, 0, RNONE, RNONE);
    src_a = RNONE; src_b = RNONE;
    #2 rst_n = 1'b0;
    tick(); tick();
    check_idle_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    //          st bb stat  icode    valE       valM   dE     dM     sA     sB     | W_stat dE    dM     rvA        rvB        cpu   h cnt
    tv[0]  = mk(0, 0, SAOK, IIRMOVQ, 'h1234,    0,     4'd3,  RNONE, 4'd0,  RNONE,   SAOK, 4'd3,  RNONE, 0,         0,         SAOK, 0, 0);
    tv[1]  = mk(0, 0, SAOK, IPOPQ,   'h10,      'h20,  RRSP,  RRSP,  4'd3,  RNONE,   SAOK, RRSP,  RRSP,  'h1234,    0,         SAOK, 0, 1);
    tv[2]  = mk(0, 0, SAOK, IOPQ,    'hAAAA,    0,     4'd5,  RNONE, RRSP,  4'd3,    SAOK, 4'd5,  RNONE, 'h20,      'h1234,    SAOK, 0, 2);
    tv[3]  = mk(0, 1, SAOK, IOPQ,    'hDEAD,    0,     4'd6,  RNONE, 4'd5,  4'd6,    SBUB, RNONE, RNONE, 'hAAAA,    0,         SAOK, 0, 3);
    tv[4]  = mk(0, 0, SAOK, IMRMOVQ, 0,         'h66,  RNONE, 4'd6,  4'd0,  4'd2,    SAOK, RNONE, 4'd6,  0,         0,         SAOK, 0, 3);
    tv[5]  = mk(1, 1, SADR, IOPQ,    'hBAD,     'hBAD, 4'd1,  4'd1,  4'd6,  RNONE,   SAOK, RNONE, 4'd6,  0,         0,         SAOK, 0, 3);
    tv[6]  = mk(0, 0, SAOK, IOPQ,    'h77,      0,     4'd7,  RNONE, 4'd6,  RNONE,   SAOK, 4'd7,  RNONE, 'h66,      0,         SAOK, 0, 4);
    tv[7]  = mk(0, 0, SADR, IMRMOVQ, 0,         'h22,  RNONE, 4'd2,  4'd7,  4'd2,    SADR, RNONE, 4'd2,  'h77,      0,         SAOK, 0, 5);
    tv[8]  = mk(0, 0, SAOK, IOPQ,    'h55,      0,     4'd5,  RNONE, 4'd2,  4'd5,    SAOK, 4'd5,  RNONE, 0,         'hAAAA,    SADR, 1, 5);
    tv[9]  = mk(0, 0, SAOK, IOPQ,    'h88,      0,     4'd8,  RNONE, 4'd5,  4'd8,    SAOK, 4'd8,  RNONE, 'hAAAA,    0,         SADR, 1, 5);
    tv[10] = mk(0, 1, SAOK, IOPQ,    'h99,      0,     4'd9,  RNONE, 4'd8,  4'd2,    SBUB, RNONE, RNONE, 0,         0,         SADR, 1, 5);

    for (int i = 0; i < 11; i++) begin
      drive(tv[i].st, tv[i].bb, tv[i].stat, tv[i].icode, tv[i].ve, tv[i].vm, tv[i].de, tv[i].dm);
      src_a = tv[i].sa; src_b = tv[i].sb;
      tick();
      chk($sformatf("v%0d W_stat", i), 64'(w_stat), 64'(tv[i].x_ws));
      chk($sformatf("v%0d W_dstE", i), 64'(w_dste), 64'(tv[i].x_de));
      chk($sformatf("v%0d W_dstM", i), 64'(w_dstm), 64'(tv[i].x_dm));
      chk($sformatf("v%0d rvalA", i), rva, tv[i].x_ra);
      chk($sformatf("v%0d rvalB", i), rvb, tv[i].x_rb);
      chk($sformatf("v%0d cpu_stat", i), 64'(cpu_stat), 64'(tv[i].x_cpu));
      chk($sformatf("v%0d halted", i), 64'(halted), 64'(tv[i].x_h));
      chk($sformatf("v%0d retired", i), 64'(cnt), 64'(tv[i].x_cnt));
    end

    // Fault is sticky only until reset; reset clears registers immediately
    rst_n = 1'b0;
    #1;
    check_idle_reset("fault_rst");
    tick();
    @(negedge clk);
    rst_n = 1'b1;

    // Read-port latency on a fresh write
    drive(0, 0, SAOK, IIRMOVQ, 'h1234, 0, 4'd3, RNONE);
    src_a = 4'd3;
    tick();
`ifdef WB_READ_BYPASS_EN
    chk("lat first edge", rva, 64'h1234);
`else
    chk("lat first edge", rva, 64'd0);
`endif
    drive(0, 1, SBUB, INOP, 0, 0, RNONE, RNONE);
    tick();
    chk("lat second edge", rva, 64'h1234);
    chk("lat retired", 64'(cnt), 64'd1);

    // Halt: earlier write lands, later write and count are blocked
    drive(0, 0, SAOK, IIRMOVQ, 'h11, 0, 4'd1, RNONE);
    tick();
    drive(0, 0, SHLT, IHALT, 0, 0, RNONE, RNONE);
    tick();
    drive(0, 0, SAOK, IIRMOVQ, 'h99, 0, 4'd9, RNONE);
    tick();
    chk("halt cpu_stat", 64'(cpu_stat), 64'(SHLT));
    chk("halt halted", 64'(halted), 64'd1);
    drive(0, 1, SBUB, INOP, 0, 0, RNONE, RNONE);
    for (int k = 0; k < 3; k++) tick();
    src_a = 4'd1; src_b = 4'd9;
    #1;
    chk("halt persists", 64'(cpu_stat), 64'(SHLT));
    chk("halt retired", 64'(cnt), 64'd2);
    chk("halt reg1", rva, 64'h11);
    chk("halt reg9", rvb, 64'd0);

    // Reset asserted mid-cycle clears W and discards the pending commit
    do_reset();
    drive(0, 0, SAOK, IIRMOVQ, 'hA0, 0, 4'd10, RNONE);
    tick();
    chk("midrst W_stat before", 64'(w_stat), 64'(SAOK));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst W_stat async", 64'(w_stat), 64'(SBUB));
    chk("midrst W_dstE async", 64'(w_dste), 64'(RNONE));
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, SBUB, INOP, 0, 0, RNONE, RNONE);
    tick(); tick();
    src_a = 4'd10;
    #1;
    chk("midrst reg10", rva, 64'd0);
    chk("midrst retired", 64'(cnt), 64'd0);

    // Stall held three cycles: no retire until released, then exactly once
    drive(0, 0, SAOK, IIRMOVQ, 'hBB, 0, 4'd11, RNONE);
    tick();
    drive(1, 1, SAOK, IOPQ, 'h1, 0, 4'd12, RNONE);
    src_a = 4'd11;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d W_dstE", k), 64'(w_dste), 64'd11);
      chk($sformatf("stall%0d W_valE", k), w_vale, 64'hBB);
      chk($sformatf("stall%0d retired", k), 64'(cnt), 64'd0);
      chk($sformatf("stall%0d reg11", k), rva, 64'd0);
    end
    drive(0, 1, SBUB, INOP, 0, 0, RNONE, RNONE);
    tick();
    chk("unstall retired", 64'(cnt), 64'd1);
    chk("unstall reg11", rva, 64'hBB);
    tick();
    chk("unstall retired hold", 64'(cnt), 64'd1);

    // Counter wraps modulo 2^CW
    do_reset();
    drive(0, 0, SAOK, INOP, 0, 0, RNONE, RNONE);
    for (int k = 0; k < 16; k++) tick();
    chk("wrap at 15", 64'(cnt), 64'd15);
    tick();
    chk("wrap to 0", 64'(cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
